ddr_rw_ctrl: RTL and testbench

DDR_RW_CTRL -- requirements
Module: ddr_rw_ctrl

---
 rtl/ddr_rw_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_ddr_rw_ctrl.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr_rw_ctrl.sv
// ddr_rw_ctrl: burst read/write sequencer in front of a MIG-style user interface.
// A write moves BURST_LEN beats from an upstream source into the MIG write path.
// A read issues BURST_LEN read commands and returns the collected data.
// Every transaction starts at BASE_ADDR, and the address advances by ADDR_STEP
// for each beat or command.
//
// Ports:
//   ui_clk, rst_n              clock; synchronous active-low reset
//   init_calib_complete        MIG calibration done; starts are ignored until set
//   wr_start / rd_start        start pulses, honoured only in IDLE (write has priority)
//   data_req, wr_ddr_data      upstream write handshake; data is valid while data_req=1
//   wr_done / rd_done          single-cycle completion pulses
//   rd_data_vld, rd_ddr_data   registered read beats
//   ddr_busy                   high while a transaction runs or calibration is pending
//   app_*                      MIG native user interface
module ddr_rw_ctrl #(
    parameter int                BURST_LEN = 64,
    parameter int                ADDR_W    = 28,
    parameter int                DATA_W    = 256,
    parameter int                ADDR_STEP = 8,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                ui_clk,
    input  logic                rst_n,
    input  logic                init_calib_complete,
    input  logic                wr_start,
    output logic                data_req,
    input  logic [DATA_W-1:0]   wr_ddr_data,
    output logic                wr_done,
    input  logic                rd_start,
    output logic                rd_data_vld,
    output logic [DATA_W-1:0]   rd_ddr_data,
    output logic                rd_done,
    output logic                ddr_busy,
    output logic [ADDR_W-1:0]   app_addr,
    output logic [2:0]          app_cmd,
    output logic                app_en,
    input  logic                app_rdy,
    output logic [DATA_W-1:0]   app_wdf_data,
    output logic                app_wdf_wren,
    output logic                app_wdf_end,
    output logic [DATA_W/8-1:0] app_wdf_mask,
    input  logic                app_wdf_rdy,
    input  logic [DATA_W-1:0]   app_rd_data,
    input  logic                app_rd_data_valid
);

    localparam int              CNT_W   = $clog2(BURST_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_END  = CNT_W'(BURST_LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
    localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(ADDR_STEP);

    localparam logic [2:0] CMD_WR = 3'b000;
    localparam logic [2:0] CMD_RD = 3'b001;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        WRITE = 3'b010,
        READ  = 3'b100
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]    cmd_cnt_q, cmd_cnt_d;
    logic [CNT_W-1:0]    rd_cnt_q, rd_cnt_d;
    logic [ADDR_W-1:0]   app_addr_q, app_addr_d;
    logic                wr_done_q, wr_done_d;
    logic                rd_done_q, rd_done_d;
    logic                rd_vld_q, rd_vld_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;

    logic                wr_fire;
    logic                rd_cmd_en;
    logic                rd_cmd_acc;
    logic                rd_beat;
    logic                start_ok;

    // Handshake qualifiers. Gating with rst_n keeps every strobe low for the
    // whole cycle in which reset is asserted, not just after the next edge.
    always_comb begin
        start_ok   = (state_q == IDLE) && init_calib_complete;
        wr_fire    = rst_n && (state_q == WRITE) && (wr_cnt_q < CNT_END)
                     && app_rdy && app_wdf_rdy;
        rd_cmd_en  = rst_n && (state_q == READ) && (cmd_cnt_q < CNT_END);
        rd_cmd_acc = rd_cmd_en && app_rdy;
        rd_beat    = (state_q == READ) && app_rd_data_valid;
    end

    // State register and datapath flops.
    always_ff @(posedge ui_clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            wr_cnt_q   <= '0;
            cmd_cnt_q  <= '0;
            rd_cnt_q   <= '0;
            app_addr_q <= BASE_ADDR;
            wr_done_q  <= 1'b0;
            rd_done_q  <= 1'b0;
            rd_vld_q   <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            cmd_cnt_q  <= cmd_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            app_addr_q <= app_addr_d;
            wr_done_q  <= wr_done_d;
            rd_done_q  <= rd_done_d;
            rd_vld_q   <= rd_vld_d;
            rd_data_q  <= rd_data_d;
        end
    end

    // Next state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start_ok && wr_start)
                    state_d = WRITE;
                else if (start_ok && rd_start)
                    state_d = READ;
            end
            WRITE: begin
                if (wr_fire && (wr_cnt_q == CNT_LAST))
                    state_d = IDLE;
            end
            READ: begin
                // The read completes on the last data beat, not on the last command.
                if (rd_beat && (rd_cnt_q == CNT_LAST))
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Next counters, address and registered read path.
    always_comb begin
        wr_cnt_d   = wr_cnt_q;
        cmd_cnt_d  = cmd_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        app_addr_d = app_addr_q;
        wr_done_d  = 1'b0;
        rd_done_d  = 1'b0;
        rd_vld_d   = rd_beat;
        rd_data_d  = rd_beat ? app_rd_data : rd_data_q;

        case (state_q)
            IDLE: begin
                // Held cleared in IDLE, so every transaction starts from a clean base.
                wr_cnt_d   = '0;
                cmd_cnt_d  = '0;
                rd_cnt_d   = '0;
                app_addr_d = BASE_ADDR;
            end
            WRITE: begin
                if (wr_fire) begin
                    wr_cnt_d   = wr_cnt_q + 1'b1;
                    app_addr_d = app_addr_q + STEP;
                    wr_done_d  = (wr_cnt_q == CNT_LAST);
                end
            end
            READ: begin
                if (rd_cmd_acc) begin
                    cmd_cnt_d  = cmd_cnt_q + 1'b1;
                    app_addr_d = app_addr_q + STEP;
                end
                if (rd_beat) begin
                    rd_cnt_d  = rd_cnt_q + 1'b1;
                    rd_done_d = (rd_cnt_q == CNT_LAST);
                end
            end
            default: ;
        endcase
    end

    // Outputs.
    always_comb begin
        data_req     = wr_fire;
        app_wdf_wren = wr_fire;
        app_wdf_end  = wr_fire;
        app_en       = wr_fire || rd_cmd_en;
        app_cmd      = (state_q == READ) ? CMD_RD : CMD_WR;
        app_addr     = app_addr_q;
        app_wdf_data = wr_ddr_data;
        app_wdf_mask = '0;
        wr_done      = wr_done_q;
        rd_done      = rd_done_q;
        rd_data_vld  = rd_vld_q;
        rd_ddr_data  = rd_data_q;
        ddr_busy     = (state_q != IDLE) || !init_calib_complete;
    end

endmodule

// File: tb/tb_ddr_rw_ctrl.sv
// Scoreboard bench for ddr_rw_ctrl: stimulus pushes expected write beats, read
// commands and read data into queues; a monitor pops and compares whenever the
// DUT presents a beat, command or done pulse.
module tb_ddr_rw_ctrl;

    localparam int BL   = 64;
    localparam int AW   = 28;
    localparam int DW   = 256;
    localparam int STEP = 8;

    logic            ui_clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            init_calib_complete = 1'b0;
    logic            wr_start = 1'b0;
    logic            rd_start = 1'b0;
    logic            data_req;
    logic [DW-1:0]   wr_ddr_data;
    logic            wr_done;
    logic            rd_data_vld;
    logic [DW-1:0]   rd_ddr_data;
    logic            rd_done;
    logic            ddr_busy;
    logic [AW-1:0]   app_addr;
    logic [2:0]      app_cmd;
    logic            app_en;
    logic            app_rdy = 1'b1;
    logic [DW-1:0]   app_wdf_data;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic [DW/8-1:0] app_wdf_mask;
    logic            app_wdf_rdy = 1'b1;
    logic [DW-1:0]   app_rd_data = '0;
    logic            app_rd_data_valid = 1'b0;

    ddr_rw_ctrl #(
        .BURST_LEN(BL),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .ADDR_STEP(STEP),
        .BASE_ADDR('0)
    ) dut (
        .ui_clk             (ui_clk),
        .rst_n              (rst_n),
        .init_calib_complete(init_calib_complete),
        .wr_start           (wr_start),
        .data_req           (data_req),
        .wr_ddr_data        (wr_ddr_data),
        .wr_done            (wr_done),
        .rd_start           (rd_start),
        .rd_data_vld        (rd_data_vld),
        .rd_ddr_data        (rd_ddr_data),
        .rd_done            (rd_done),
        .ddr_busy           (ddr_busy),
        .app_addr           (app_addr),
        .app_cmd            (app_cmd),
        .app_en             (app_en),
        .app_rdy            (app_rdy),
        .app_wdf_data       (app_wdf_data),
        .app_wdf_wren       (app_wdf_wren),
        .app_wdf_end        (app_wdf_end),
        .app_wdf_mask       (app_wdf_mask),
        .app_wdf_rdy        (app_wdf_rdy),
        .app_rd_data        (app_rd_data),
        .app_rd_data_valid  (app_rd_data_valid)
    );

    initial forever #5 ui_clk = ~ui_clk;

    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] data; bit last; } wr_exp_t;
    typedef struct { logic [DW-1:0] data; bit last; } rd_exp_t;
    typedef struct { int unsigned due; logic [DW-1:0] data; } mig_rsp_t;

    wr_exp_t       exp_wr[$];
    rd_exp_t       exp_rd[$];
    logic [AW-1:0] exp_cmd[$];
    mig_rsp_t      mig_q[$];

    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;

    int unsigned cyc = 0;
    int unsigned up_idx = 0;
    int unsigned mig_idx = 0;
    logic [15:0] wr_seed = 16'h0000;
    bit          bp_mode = 1'b0;
    bit          rnd_mode = 1'b0;
    bit          stray = 1'b0;

    int unsigned txn_beats = 0;
    int unsigned first_cyc = 0;
    int unsigned last_cyc = 0;
    int unsigned wr_done_cnt = 0;
    int unsigned rd_done_cnt = 0;
    bit          wr_due = 1'b0;
    logic        prev_valid = 1'b0;

    function automatic logic [DW-1:0] wpat(input logic [15:0] seed, input int unsigned i);
        logic [31:0] w;
        w = {seed, i[15:0]};
        return {8{w}};
    endfunction

    function automatic logic [DW-1:0] rpat(input int unsigned i);
        logic [31:0] w;
        w = {16'hC0DE, i[15:0]};
        return {8{w}};
    endfunction

    assign wr_ddr_data = wpat(wr_seed, up_idx);

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b", name, act, exp);
        end
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chki(input string name, input int unsigned act, input int unsigned exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Environment: upstream data source, ready patterns, and a MIG read model
    // with a fixed 10-cycle command-to-data latency.
    initial begin
        bit adv;
        forever begin
            @(negedge ui_clk);
            adv = data_req;
            if (app_en && app_rdy && app_cmd == 3'b001) begin
                mig_q.push_back('{due: cyc + 10, data: rpat(mig_idx)});
                mig_idx++;
            end
            @(posedge ui_clk);
            #1;
            cyc++;
            if (adv) up_idx++;
            app_wdf_rdy = bp_mode ? ((cyc % 3) != 0) : 1'b1;
            app_rdy     = rnd_mode ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mig_q.size() > 0 && mig_q[0].due == cyc) begin
                app_rd_data_valid = 1'b1;
                app_rd_data       = mig_q[0].data;
                void'(mig_q.pop_front());
            end else begin
                app_rd_data_valid = stray;
                app_rd_data       = stray ? {8{32'hDEADBEEF}} : '0;
            end
        end
    end

    // Monitor.
    initial begin
        wr_exp_t e;
        rd_exp_t r;
        forever begin
            @(negedge ui_clk);
            if (rst_n) begin
                if (wr_due) begin
                    chk1("wr_done_pulse", wr_done, 1'b1);
                    chk1("busy_at_wr_done", ddr_busy, 1'b0);
                    wr_due = 1'b0;
                    wr_done_cnt++;
                end else if (wr_done) begin
                    chk1("spurious_wr_done", wr_done, 1'b0);
                end

                if (data_req) begin
                    if (exp_wr.size() == 0) begin
                        chk1("unexpected_data_req", data_req, 1'b0);
                    end else begin
                        e = exp_wr.pop_front();
                        chkw("wr_addr", DW'(app_addr), DW'(e.addr));
                        chkw("wr_data", app_wdf_data, e.data);
                        chk1("wr_strobes", app_en & app_wdf_wren & app_wdf_end, 1'b1);
                        chkw("wr_cmd", DW'(app_cmd), DW'(3'b000));
                        chk1("data_req_needs_ready", app_rdy & app_wdf_rdy, 1'b1);
                        if (txn_beats == 0) first_cyc = cyc;
                        last_cyc = cyc;
                        txn_beats++;
                        if (e.last) wr_due = 1'b1;
                    end
                end

                if (app_en && app_rdy && app_cmd == 3'b001) begin
                    if (exp_cmd.size() == 0)
                        chk1("extra_read_cmd", app_en, 1'b0);
                    else
                        chkw("rd_cmd_addr", DW'(app_addr), DW'(exp_cmd.pop_front()));
                end

                if (rd_data_vld) begin
                    chk1("rd_vld_latency", prev_valid, 1'b1);
                    if (exp_rd.size() == 0) begin
                        chk1("unexpected_rd_data_vld", rd_data_vld, 1'b0);
                    end else begin
                        r = exp_rd.pop_front();
                        chkw("rd_data", rd_ddr_data, r.data);
                        chk1("rd_done_with_beat", rd_done, r.last);
                        if (r.last) rd_done_cnt++;
                    end
                end else if (rd_done) begin
                    chk1("rd_done_without_beat", rd_done, 1'b0);
                end
            end
            prev_valid = app_rd_data_valid;
        end
    end

    task automatic start_write(input logic [15:0] seed, input bit also_rd);
        for (int i = 0; i < BL; i++)
            exp_wr.push_back('{addr: AW'(i * STEP), data: wpat(seed, i), last: (i == BL - 1)});
        @(posedge ui_clk);
        #1;
        wr_seed   = seed;
        up_idx    = 0;
        txn_beats = 0;
        wr_start  = 1'b1;
        rd_start  = also_rd;
        @(posedge ui_clk);
        #1;
        wr_start = 1'b0;
        rd_start = 1'b0;
    endtask

    task automatic run_write(input logic [15:0] seed, input bit also_rd);
        int unsigned target;
        target = wr_done_cnt + 1;
        start_write(seed, also_rd);
        for (int k = 0; k < 400; k++) begin
            if (wr_done_cnt >= target) break;
            @(posedge ui_clk);
            #1;
        end
        chk1("write_completes", wr_done_cnt >= target, 1'b1);
        chki("write_beats", txn_beats, BL);
        chki("write_queue_left", exp_wr.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned target;
        bit en_seen;

        // Reset values
        repeat (3) @(posedge ui_clk);
        @(negedge ui_clk);
        chk1("rst_data_req", data_req, 1'b0);
        chk1("rst_wr_done", wr_done, 1'b0);
        chk1("rst_rd_done", rd_done, 1'b0);
        chk1("rst_rd_data_vld", rd_data_vld, 1'b0);
        chk1("rst_app_en", app_en, 1'b0);
        chk1("rst_app_wdf_wren", app_wdf_wren, 1'b0);
        chkw("rst_rd_ddr_data", rd_ddr_data, '0);
        chkw("rst_app_addr", DW'(app_addr), '0);
        chkw("wdf_mask", DW'(app_wdf_mask), '0);
        chk1("rst_busy_uncal", ddr_busy, 1'b1);
        @(posedge ui_clk);
        #1;
        rst_n = 1'b1;

        // Calibration gate
        wr_start = 1'b1;
        @(posedge ui_clk);
        #1;
        wr_start = 1'b0;
        en_seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge ui_clk);
            chk1("calib_gate_busy", ddr_busy, 1'b1);
            en_seen = en_seen | app_en;
        end
        chk1("calib_gate_app_en", en_seen, 1'b0);
        init_calib_complete = 1'b1;
        @(negedge ui_clk);
        chk1("idle_busy", ddr_busy, 1'b0);

        // Write, ready always high: 64 back-to-back beats
        run_write(16'h1111, 1'b0);
        chki("consecutive_beat_span", last_cyc - first_cyc, BL - 1);

        // Write with app_wdf_rdy low every third cycle
        bp_mode = 1'b1;
        run_write(16'h2222, 1'b0);
        chk1("backpressure_stretches", (last_cyc - first_cyc) > (BL - 1), 1'b1);
        bp_mode = 1'b0;

        // Read with random app_rdy
        rnd_mode = 1'b1;
        mig_idx  = 0;
        for (int i = 0; i < BL; i++) begin
            exp_cmd.push_back(AW'(i * STEP));
            exp_rd.push_back('{data: rpat(i), last: (i == BL - 1)});
        end
        target = rd_done_cnt + 1;
        @(posedge ui_clk);
        #1;
        rd_start = 1'b1;
        @(posedge ui_clk);
        #1;
        rd_start = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (rd_done_cnt >= target) break;
            @(posedge ui_clk);
            #1;
        end
        chk1("read_completes", rd_done_cnt >= target, 1'b1);
        chki("read_cmds_issued", mig_idx, BL);
        chki("read_cmd_queue_left", exp_cmd.size(), 0);
        chki("read_data_queue_left", exp_rd.size(), 0);
        repeat (20) @(posedge ui_clk);
        chki("no_extra_read_cmds", mig_idx, BL);
        rnd_mode = 1'b0;

        // Simultaneous starts: write wins, no read commands appear
        run_write(16'h3333, 1'b1);
        chki("no_read_on_tie", mig_idx, BL);

        // Stray read data in IDLE must be dropped
        @(negedge ui_clk);
        stray = 1'b1;
        @(negedge ui_clk);
        stray = 1'b0;
        @(negedge ui_clk);
        chk1("stray_vld_dropped", rd_data_vld, 1'b0);

        // Reset at write beat 30 aborts without wr_done
        start_write(16'h4444, 1'b0);
        for (int k = 0; k < 200; k++) begin
            if (txn_beats >= 30) break;
            @(posedge ui_clk);
            #1;
        end
        chki("abort_reached_beat30", txn_beats, 30);
        rst_n = 1'b0;
        exp_wr.delete();
        @(negedge ui_clk);
        chk1("abort_in_rst_data_req", data_req, 1'b0);
        chk1("abort_in_rst_app_en", app_en, 1'b0);
        @(posedge ui_clk);
        #1;
        @(negedge ui_clk);
        chk1("abort_busy", ddr_busy, 1'b0);
        chk1("abort_wr_done", wr_done, 1'b0);
        chk1("abort_wren", app_wdf_wren, 1'b0);
        chkw("abort_addr", DW'(app_addr), '0);
        @(posedge ui_clk);
        #1;
        rst_n = 1'b1;
        repeat (4) @(posedge ui_clk);
        #1;
        run_write(16'h5555, 1'b0);

        repeat (5) @(posedge ui_clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
